// File: rtl/sumador_serie_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
interface sumador_serie_if #(
    parameter int N = 8
) ();
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         carry_out;

    // Surrounding datapath: issues operations and reads results.
    modport master (
        output start, a, b,
        input  busy, done, sum, carry_out
    );

    // Adder controller side.
    modport slave (
        input  start, a, b,
        output busy, done, sum, carry_out
    );
endinterface : sumador_serie_if

// File: rtl/sumador_serie.sv
// Bit-serial N-bit adder: two half adders plus an OR form a 1-bit full
// adder that is stepped over the operands LSB first, one bit per cycle.

// Half adder building block.
module semisumador (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule : semisumador

// State   | meaning
// --------+---------------------------------------------------------
// REPOSO  | idle; start loads operands, clears carry and counter
// SUMA    | one bit pair per edge, counter 0..N-1
// FIN     | result valid, done high for this single cycle
module sumador_serie #(
    parameter int N = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    sumador_serie_if.slave    bus
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        SUMA   = 2'd1,
        FIN    = 2'd2
    } state_t;

    state_t          state_q, state_d;

    logic [N-1:0]    a_sr_q, a_sr_d;
    logic [N-1:0]    b_sr_q, b_sr_d;
    logic            carry_q, carry_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    // Holds the N-1 bits already produced; the final bit is merged on the
    // last edge straight into the result register.
    logic [N-2:0]    res_sr_q, res_sr_d;
    logic [N-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;

    logic            busy_w;
    logic            done_w;

    logic            s0_w, c0_w, s_w, c1_w, cnext_w;
    logic [N-1:0]    sh_w;
    logic            last_bit_w;

    semisumador u_hs0 (
        .a_i (a_sr_q[0]),
        .b_i (b_sr_q[0]),
        .s_o (s0_w),
        .c_o (c0_w)
    );

    semisumador u_hs1 (
        .a_i (s0_w),
        .b_i (carry_q),
        .s_o (s_w),
        .c_o (c1_w)
    );

    assign cnext_w    = c0_w | c1_w;
    assign sh_w       = {s_w, res_sr_q};
    assign last_bit_w = (cnt_q == CW'(N - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= REPOSO;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; start is only looked at in REPOSO.
    always_comb begin
        state_d = state_q;
        case (state_q)
            REPOSO: if (bus.start) state_d = SUMA;
            SUMA:   if (last_bit_w) state_d = FIN;
            FIN:    state_d = REPOSO;
            default: state_d = REPOSO;
        endcase
    end

    // Handshake outputs decoded from the registered state only.
    always_comb begin
        busy_w = 1'b0;
        done_w = 1'b0;
        case (state_q)
            SUMA: busy_w = 1'b1;
            FIN: begin
                busy_w = 1'b1;
                done_w = 1'b1;
            end
            default: begin
                busy_w = 1'b0;
                done_w = 1'b0;
            end
        endcase
    end

    // Datapath next values: operand capture, serial step, result commit.
    always_comb begin
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        res_sr_d = res_sr_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        case (state_q)
            REPOSO: begin
                if (bus.start) begin
                    a_sr_d   = bus.a;
                    b_sr_d   = bus.b;
                    carry_d  = 1'b0;
                    cnt_d    = '0;
                    res_sr_d = '0;
                end
            end
            SUMA: begin
                a_sr_d   = {1'b0, a_sr_q[N-1:1]};
                b_sr_d   = {1'b0, b_sr_q[N-1:1]};
                carry_d  = cnext_w;
                cnt_d    = cnt_q + CW'(1);
                res_sr_d = sh_w[N-1:1];
                if (last_bit_w) begin
                    sum_d  = sh_w;
                    cout_d = cnext_w;
                end
            end
            default: begin
                a_sr_d = a_sr_q;
            end
        endcase
    end

    // Datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            res_sr_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            res_sr_q <= res_sr_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign bus.busy      = busy_w;
    assign bus.done      = done_w;
    assign bus.sum       = sum_q;
    assign bus.carry_out = cout_q;

endmodule : sumador_serie

// File: tb/tb_sumador_serie.sv
// Bench for the bit-serial adder: scoreboard on the N=8 instance, direct
// latency check on an N=4 instance.
module tb_sumador_serie;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [8:0] res;
        int         t_acc;
    } exp_t;

    exp_t       sb[$];
    logic [8:0] last_res = '0;
    int         blen = 0;
    int         t_prev;

    sumador_serie_if #(.N(8)) bus8 ();
    sumador_serie_if #(.N(4)) bus4 ();

    sumador_serie #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
    sumador_serie #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Bounded wait until the N=8 adder is idle, ending on a falling edge.
    task automatic wait_idle();
        int k = 0;
        while (bus8.busy === 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", {31'd0, bus8.busy}, 32'd0);
    endtask

    // Issue one operation with a single-cycle start and record the expectation.
    task automatic op8(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        wait_idle();
        bus8.a     = a;
        bus8.b     = b;
        bus8.start = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        e.res   = {1'b0, a} + {1'b0, b};
        e.t_acc = cyc;
        sb.push_back(e);
    endtask

    // Result monitor: pops on done, checks held values otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_res = '0;
            blen     = 0;
            sb.delete();
        end
        if (bus8.done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("done_without_start", {31'd0, bus8.done}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sum",       {24'd0, bus8.sum}, {24'd0, e.res[7:0]});
                chk("carry_out", {31'd0, bus8.carry_out}, {31'd0, e.res[8]});
                chk("latency",   cyc - e.t_acc, 32'd8);
                last_res = e.res;
            end
        end else begin
            chk("hold", {23'd0, bus8.carry_out, bus8.sum}, {23'd0, last_res});
        end
        if (bus8.busy === 1'b1) begin
            blen++;
        end else if (blen > 0) begin
            chk("busy_len", blen, 32'd9);
            blen = 0;
        end
    end

    initial begin
        exp_t e;
        rst_n      = 1'b0;
        bus8.start = 1'b0;
        bus8.a     = '0;
        bus8.b     = '0;
        bus4.start = 1'b0;
        bus4.a     = '0;
        bus4.b     = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, bus8.busy}, 32'd0);
        chk("rst_done", {31'd0, bus8.done}, 32'd0);
        chk("rst_sum",  {24'd0, bus8.sum}, 32'd0);
        chk("rst_cout", {31'd0, bus8.carry_out}, 32'd0);
        rst_n = 1'b1;

        op8(8'd3,   8'd5);
        op8(8'd255, 8'd1);
        op8(8'd0,   8'd0);
        op8(8'hA5,  8'h5B);
        op8(8'h7F,  8'h01);

        // Start pulse with changed operands while busy must be ignored.
        op8(8'h3C, 8'h0F);
        repeat (3) @(posedge clk);
        #1;
        bus8.a     = 8'hFF;
        bus8.b     = 8'hFF;
        bus8.start = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;

        // Start held high: back-to-back accepts every N+2 cycles.
        wait_idle();
        bus8.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_idle();
            bus8.a = 8'(i * 37 + 11);
            bus8.b = 8'(i * 90 + 200);
            @(posedge clk);
            #1;
            e.res   = {1'b0, bus8.a} + {1'b0, bus8.b};
            e.t_acc = cyc;
            sb.push_back(e);
            if (i > 0) chk("period", cyc - t_prev, 32'd10);
            t_prev = cyc;
        end
        bus8.start = 1'b0;

        // Reset after three SUMA edges aborts the operation.
        wait_idle();
        bus8.a     = 8'hF0;
        bus8.b     = 8'h0F;
        bus8.start = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, bus8.busy}, 32'd0);
        chk("abort_done", {31'd0, bus8.done}, 32'd0);
        chk("abort_sum",  {24'd0, bus8.sum}, 32'd0);
        chk("abort_cout", {31'd0, bus8.carry_out}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        op8(8'd100, 8'd27);

        // N=4 instance: 9+9 wraps to 2 with carry, done 4 cycles after accept.
        @(negedge clk);
        bus4.a     = 4'd9;
        bus4.b     = 4'd9;
        bus4.start = 1'b1;
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("n4_done_early", {31'd0, bus4.done}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("n4_done", {31'd0, bus4.done}, 32'd1);
        chk("n4_sum",  {28'd0, bus4.sum}, 32'd2);
        chk("n4_cout", {31'd0, bus4.carry_out}, 32'd1);

        wait_idle();
        repeat (3) @(negedge clk);
        chk("sb_drain", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sumador_serie
